fifo_serializer: RTL

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

---
 rtl/fifo_ser_pkg.sv | 19 +
 rtl/bit_timer.sv | 36 +++
 rtl/fifo_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared state encoding and parity helper for the FIFO-to-serial transmitter.
package fifo_ser_pkg;

  localparam int PAR_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_e;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-time down-counter: load restarts at CLKS_PER_BIT-1, tick marks the last cycle of a bit.
// Latency: tick is a pure decode of the count register; no backpressure.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [15:0] LOAD_VAL = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (count_q != 16'd0) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == 16'd0);

endmodule

// File: rtl/fifo_serializer.sv
// Pops one FIFO word per frame and sends start, LSB-first data, optional even parity, stop.
// Latency: tx goes low one cycle after the pop strobe; FIFO is only sampled in IDLE.
module fifo_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_val,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int              IDX_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  ser_state_e            state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  tx_q;
  logic                  tick;
  logic                  load;

  assign fifo_read = (state_q == IDLE) && fifo_val && !reset;

  // Restart the bit timer at every bit boundary except the end of STOP.
  assign load = fifo_read ||
                (tick && (state_q == START || state_q == DATA || state_q == PARITY));

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .tick (tick)
  );

  // The shift register rotates rather than shifts, so after all data bits it
  // holds the original word again and parity can be taken from it directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_val) begin
            shreg_q <= fifo_data;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shreg_q[0];
            shreg_q <= {shreg_q[0], shreg_q[DATA_WIDTH-1:1]};
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (PARITY_EN) begin
                tx_q    <= even_parity(PAR_MAX_W'(shreg_q));
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shreg_q[0];
              shreg_q <= {shreg_q[0], shreg_q[DATA_WIDTH-1:1]};
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && tick;

endmodule
